// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a two-entry skid buffer and a registered ready_o.
// MAIN drives the EX-side outputs; SKID catches the one beat that can arrive while EX stalls.
module id_ex_skid #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  input  logic            flush_i
);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            wen;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam entry_t NOP_ENTRY = '{
    inst: XLEN'(NOP_INST),
    addr: '0,
    op1:  '0,
    op2:  '0,
    rd:   '0,
    wen:  1'b0
  };

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign in_entry = '{
    inst: inst_i,
    addr: inst_addr_i,
    op1:  op1_i,
    op2:  op2_i,
    rd:   rd_addr_i,
    wen:  reg_wen_i
  };

  assign accept = valid_i & ready_q;
  assign drain  = valid_q & ready_i;

  // MAIN is reloaded with the NOP pattern whenever the stage empties, so the
  // outputs come straight from flops without a valid-gated mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (drain) begin
          main_d  = NOP_ENTRY;
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = NOP_ENTRY;
        skid_d  = '0;
        state_d = EMPTY;
      end
    endcase

    // A redirect from EX discards everything, including a beat accepted this cycle.
    if (flush_i) begin
      main_d  = NOP_ENTRY;
      skid_d  = '0;
      state_d = EMPTY;
    end

    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_ENTRY;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign inst_o      = main_q.inst;
  assign inst_addr_o = main_q.addr;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign rd_addr_o   = main_q.rd;
  assign reg_wen_o   = main_q.wen;

endmodule
